// File: rtl/nano4k_flash_scheduler.sv
// nano4k_flash_scheduler: flash reset sequence plus round-robin READ/WREN+PP sequencing for two clients
module nano4k_flash_scheduler #(
  parameter int CMD_HOLD = 32,
  parameter int CS_GAP = 4,
  parameter int RST_WAIT = 64
) (
  input  logic        interfaceClk,
  input  logic        reset,
  input  logic        req0Valid,
  input  logic [21:0] req0Addr,
  input  logic [8:0]  req0Len,
  output logic        req0Ready,
  output logic [7:0]  req0Data,
  output logic        req0DataValid,
  input  logic        req1Valid,
  input  logic        req1Write,
  input  logic [21:0] req1Addr,
  input  logic [8:0]  req1Len,
  output logic        req1Ready,
  input  logic [7:0]  req1WrData,
  output logic        req1WrTake,
  output logic [7:0]  req1Data,
  output logic        req1DataValid,
  output logic        req1Error,
  output logic        done,
  output logic        busy,
  output logic        initDone,
  output logic        flashEnable_n,
  output logic [7:0]  flashCmd,
  output logic [21:0] flashAddr,
  output logic [7:0]  flashWrData,
  input  logic [7:0]  flashRdData,
  input  logic        flashRdValid,
  input  logic        flashWrReady
);
  localparam logic [3:0] INIT_RSTEN = 4'd0, INIT_RST = 4'd1, INIT_WAIT = 4'd2, IDLE = 4'd3,
                         GAP = 4'd4, RD = 4'd5, WREN = 4'd6, WR = 4'd7, ZERO = 4'd8;
  localparam logic [15:0] HOLD_LAST = 16'(CMD_HOLD - 1);
  localparam logic [15:0] GAP_LAST = 16'(CS_GAP - 1);
  localparam logic [15:0] WAIT_LAST = 16'(RST_WAIT - 1);
  logic [3:0] state, gapNext;
  logic [15:0] tmr;
  logic [8:0] byteCnt, lenQ, selLen;
  logic [21:0] selAddr;
  logic [2:0] hdrCnt;
  logic portQ, rrPort, pick, isWrite, badWrite, lastByte;
  always_comb begin
    pick = req0Valid && req1Valid ? rrPort : req1Valid;
    selLen = pick ? req1Len : req0Len;
    selAddr = pick ? req1Addr : req0Addr;
    isWrite = pick && req1Write;
    badWrite = isWrite && (10'(req1Addr[7:0]) + 10'(req1Len) > 10'd256);
    lastByte = byteCnt + 9'd1 == lenQ;
  end
  assign busy = initDone && state != IDLE;
  assign flashWrData = state == WR ? req1WrData : 8'h00;
  // header strobes (opcode + 3 address bytes) never consume client data
  assign req1WrTake = state == WR && flashWrReady && hdrCnt == 3'd4;
  always_ff @(posedge interfaceClk) begin
    if (reset) begin
      state <= INIT_RSTEN;
      gapNext <= INIT_RST;
      tmr <= '0;
      byteCnt <= '0;
      lenQ <= '0;
      hdrCnt <= '0;
      portQ <= 1'b0;
      rrPort <= 1'b0;
      initDone <= 1'b0;
      flashEnable_n <= 1'b1;
      flashCmd <= 8'h00;
      flashAddr <= '0;
      req0Ready <= 1'b0;
      req1Ready <= 1'b0;
      req1Error <= 1'b0;
      done <= 1'b0;
      req0Data <= 8'h00;
      req1Data <= 8'h00;
      req0DataValid <= 1'b0;
      req1DataValid <= 1'b0;
    end else begin
      req0Ready <= 1'b0;
      req1Ready <= 1'b0;
      req1Error <= 1'b0;
      done <= 1'b0;
      req0DataValid <= 1'b0;
      req1DataValid <= 1'b0;
      case (state)
        INIT_RSTEN, INIT_RST, WREN: begin
          // only the first cycle out of reset arrives here with chip select still high
          if (flashEnable_n) begin
            flashEnable_n <= 1'b0;
            flashCmd <= 8'h66;
          end else if (tmr == HOLD_LAST) begin
            tmr <= '0;
            flashEnable_n <= 1'b1;
            gapNext <= state == INIT_RSTEN ? INIT_RST : state == INIT_RST ? INIT_WAIT : WR;
            state <= GAP;
          end else tmr <= tmr + 16'd1;
        end
        GAP: begin
          if (tmr == GAP_LAST) begin
            tmr <= '0;
            state <= gapNext;
            // drop chip select on the exit edge so the gap is exactly CS_GAP cycles
            if (gapNext == INIT_RST || gapNext == WR) begin
              flashEnable_n <= 1'b0;
              flashCmd <= gapNext == WR ? 8'h02 : 8'h99;
            end
          end else tmr <= tmr + 16'd1;
        end
        INIT_WAIT: begin
          if (tmr == WAIT_LAST) begin
            tmr <= '0;
            initDone <= 1'b1;
            state <= IDLE;
          end else tmr <= tmr + 16'd1;
        end
        IDLE: begin
          if (req0Valid || req1Valid) begin
            rrPort <= ~pick;
            if (badWrite) req1Error <= 1'b1;
            else begin
              req0Ready <= ~pick;
              req1Ready <= pick;
              portQ <= pick;
              lenQ <= selLen;
              flashAddr <= selAddr;
              byteCnt <= '0;
              hdrCnt <= '0;
              if (selLen == 9'd0) state <= ZERO;
              else begin
                flashEnable_n <= 1'b0;
                flashCmd <= isWrite ? 8'h06 : 8'h03;
                state <= isWrite ? WREN : RD;
              end
            end
          end
        end
        ZERO: begin
          done <= 1'b1;
          state <= IDLE;
        end
        RD: begin
          if (flashRdValid) begin
            byteCnt <= byteCnt + 9'd1;
            if (portQ) begin
              req1Data <= flashRdData;
              req1DataValid <= 1'b1;
            end else begin
              req0Data <= flashRdData;
              req0DataValid <= 1'b1;
            end
            if (lastByte) begin
              flashEnable_n <= 1'b1;
              done <= 1'b1;
              gapNext <= IDLE;
              state <= GAP;
            end
          end
        end
        WR: begin
          if (flashWrReady) begin
            if (hdrCnt != 3'd4) hdrCnt <= hdrCnt + 3'd1;
            else begin
              byteCnt <= byteCnt + 9'd1;
              if (lastByte) begin
                flashEnable_n <= 1'b1;
                done <= 1'b1;
                gapNext <= IDLE;
                state <= GAP;
              end
            end
          end
        end
        default: state <= INIT_RSTEN;
      endcase
    end
  end
endmodule

// File: tb/tb_nano4k_flash_scheduler.sv
// tb_nano4k_flash_scheduler: directed checks of init, arbitration, read, write, rejection and reset abort
module tb_nano4k_flash_scheduler;
  logic interfaceClk = 1'b0;
  logic reset = 1'b1;
  logic req0Valid = 1'b0, req1Valid = 1'b0, req1Write = 1'b0;
  logic [21:0] req0Addr = '0, req1Addr = '0;
  logic [8:0] req0Len = '0, req1Len = '0;
  logic [7:0] req1WrData = 8'h00, flashRdData = 8'h00;
  logic flashRdValid = 1'b0, flashWrReady = 1'b0;
  logic req0Ready, req0DataValid, req1Ready, req1WrTake, req1DataValid, req1Error;
  logic done, busy, initDone, flashEnable_n;
  logic [7:0] req0Data, req1Data, flashCmd, flashWrData;
  logic [21:0] flashAddr;
  int total = 0, bad = 0;
  int nDone = 0, nErr = 0, nRdy1 = 0, nLow = 0;
  logic [7:0] rd0[$];
  logic grants[$];

  always #5 interfaceClk = ~interfaceClk;

  nano4k_flash_scheduler dut (
    .interfaceClk(interfaceClk), .reset(reset),
    .req0Valid(req0Valid), .req0Addr(req0Addr), .req0Len(req0Len), .req0Ready(req0Ready),
    .req0Data(req0Data), .req0DataValid(req0DataValid),
    .req1Valid(req1Valid), .req1Write(req1Write), .req1Addr(req1Addr), .req1Len(req1Len),
    .req1Ready(req1Ready), .req1WrData(req1WrData), .req1WrTake(req1WrTake),
    .req1Data(req1Data), .req1DataValid(req1DataValid), .req1Error(req1Error),
    .done(done), .busy(busy), .initDone(initDone),
    .flashEnable_n(flashEnable_n), .flashCmd(flashCmd), .flashAddr(flashAddr),
    .flashWrData(flashWrData), .flashRdData(flashRdData), .flashRdValid(flashRdValid),
    .flashWrReady(flashWrReady)
  );

  always @(negedge interfaceClk) begin
    if (done) nDone++;
    if (req0DataValid) rd0.push_back(req0Data);
    if (req0Ready) grants.push_back(1'b0);
    if (req1Ready) begin grants.push_back(1'b1); nRdy1++; end
    if (req1Error) nErr++;
    if (!flashEnable_n) nLow++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic runLen(input logic lvl, output int n);
    n = 0;
    while (flashEnable_n == lvl && n < 500) begin @(negedge interfaceClk); n++; end
  endtask

  task automatic issue(input logic p, input logic w, input logic [21:0] a, input logic [8:0] l);
    int n = 0;
    if (p) begin req1Valid = 1'b1; req1Write = w; req1Addr = a; req1Len = l; end
    else begin req0Valid = 1'b1; req0Addr = a; req0Len = l; end
    do begin @(negedge interfaceClk); n++; end
    while (!(req0Ready || req1Ready || req1Error) && n < 50);
    chk("grant_seen", 32'(req0Ready || req1Ready || req1Error), 32'd1);
    req0Valid = 1'b0;
    req1Valid = 1'b0;
  endtask

  task automatic rdStrobe(input logic [7:0] d);
    repeat (2) @(negedge interfaceClk);
    flashRdData = d;
    flashRdValid = 1'b1;
    @(negedge interfaceClk);
    flashRdValid = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (busy && n < 100) begin @(negedge interfaceClk); n++; end
    chk("idle_reached", 32'(busy), 32'd0);
  endtask

  initial begin
    int n, takes, snapDone, snapLow, snapErr, snapRdy;
    // reset state and init sequence
    repeat (3) @(negedge interfaceClk);
    chk("rst_en_n", 32'(flashEnable_n), 32'd1);
    chk("rst_cmd", 32'(flashCmd), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_init", 32'(initDone), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    @(negedge interfaceClk);
    chk("rsten_cmd", 32'(flashCmd), 32'h66);
    runLen(1'b0, n);
    chk("rsten_len", n, 32);
    runLen(1'b1, n);
    chk("gap1_len", n, 4);
    chk("rst_opcode", 32'(flashCmd), 32'h99);
    runLen(1'b0, n);
    chk("rst_len", n, 32);
    n = 0;
    while (!initDone && n < 200) begin @(negedge interfaceClk); n++; end
    chk("init_wait", n, 68);
    chk("init_en_n", 32'(flashEnable_n), 32'd1);

    // arbitration with both ports valid, len 0 so the flash stays untouched
    snapLow = nLow;
    snapDone = nDone;
    grants.delete();
    req0Valid = 1'b1;
    req1Valid = 1'b1;
    n = 0;
    while (grants.size() < 3 && n < 60) begin @(negedge interfaceClk); n++; end
    req0Valid = 1'b0;
    req1Valid = 1'b0;
    repeat (3) @(negedge interfaceClk);
    chk("arb_count", grants.size(), 3);
    chk("arb_first", 32'(grants[0]), 32'd0);
    chk("arb_second", 32'(grants[1]), 32'd1);
    chk("arb_third", 32'(grants[2]), 32'd0);
    chk("arb_done", nDone - snapDone, 3);
    chk("arb_noflash", nLow - snapLow, 0);

    // port 0 read of 3 bytes
    rd0.delete();
    snapDone = nDone;
    issue(1'b0, 1'b0, 22'h000100, 9'd3);
    chk("rd_ready", 32'(req0Ready), 32'd1);
    chk("rd_en_n", 32'(flashEnable_n), 32'd0);
    chk("rd_cmd", 32'(flashCmd), 32'h03);
    chk("rd_addr", 32'(flashAddr), 32'h100);
    rdStrobe(8'hA1);
    rdStrobe(8'hB2);
    chk("rd_mid_en_n", 32'(flashEnable_n), 32'd0);
    rdStrobe(8'hC3);
    chk("rd_last_dv", 32'(req0DataValid), 32'd1);
    chk("rd_last_data", 32'(req0Data), 32'hC3);
    chk("rd_done", 32'(done), 32'd1);
    chk("rd_release", 32'(flashEnable_n), 32'd1);
    @(negedge interfaceClk);
    chk("rd_count", rd0.size(), 3);
    chk("rd_byte0", 32'(rd0[0]), 32'hA1);
    chk("rd_byte1", 32'(rd0[1]), 32'hB2);
    rdStrobe(8'hEE);
    @(negedge interfaceClk);
    chk("rd_extra_ignored", rd0.size(), 3);
    chk("rd_done_once", nDone - snapDone, 1);
    waitIdle();

    // port 1 page program ending exactly at the page boundary
    snapDone = nDone;
    req1WrData = 8'h10;
    takes = 0;
    issue(1'b1, 1'b1, 22'h0000F0, 9'd16);
    chk("wr_ready", 32'(req1Ready), 32'd1);
    chk("wren_cmd", 32'(flashCmd), 32'h06);
    runLen(1'b0, n);
    chk("wren_len", n, 32);
    runLen(1'b1, n);
    chk("wr_gap", n, 4);
    chk("pp_cmd", 32'(flashCmd), 32'h02);
    chk("pp_addr", 32'(flashAddr), 32'hF0);
    for (int i = 0; i < 20; i++) begin
      flashWrReady = 1'b1;
      #1;
      chk("wr_take", 32'(req1WrTake), 32'(i >= 4));
      if (req1WrTake) begin
        chk("wr_data", 32'(flashWrData), 32'(12 + i));
        takes++;
      end
      @(negedge interfaceClk);
      flashWrReady = 1'b0;
      req1WrData = 8'(16 + takes);
      if (i == 19) begin
        chk("wr_release", 32'(flashEnable_n), 32'd1);
        chk("wr_done", 32'(done), 32'd1);
      end
      @(negedge interfaceClk);
    end
    chk("wr_takes", takes, 16);
    chk("wr_done_once", nDone - snapDone, 1);
    waitIdle();

    // page-crossing write is rejected, then a len 0 read
    snapLow = nLow;
    snapErr = nErr;
    snapRdy = nRdy1;
    issue(1'b1, 1'b1, 22'h0000F8, 9'd16);
    chk("err_pulse", 32'(req1Error), 32'd1);
    repeat (6) @(negedge interfaceClk);
    chk("err_once", nErr - snapErr, 1);
    chk("err_no_ready", nRdy1 - snapRdy, 0);
    chk("err_noflash", nLow - snapLow, 0);
    issue(1'b0, 1'b0, 22'h000123, 9'd0);
    chk("zero_ready", 32'(req0Ready), 32'd1);
    @(negedge interfaceClk);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_busy", 32'(busy), 32'd0);
    @(negedge interfaceClk);
    chk("zero_noflash", nLow - snapLow, 0);

    // reset during byte 2 of an 8-byte read
    issue(1'b0, 1'b0, 22'h002000, 9'd8);
    rdStrobe(8'h11);
    snapDone = nDone;
    repeat (2) @(negedge interfaceClk);
    flashRdData = 8'h22;
    flashRdValid = 1'b1;
    reset = 1'b1;
    @(negedge interfaceClk);
    flashRdValid = 1'b0;
    chk("abort_en_n", 32'(flashEnable_n), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_dv", 32'(req0DataValid), 32'd0);
    chk("abort_init", 32'(initDone), 32'd0);
    @(negedge interfaceClk);
    reset = 1'b0;
    @(negedge interfaceClk);
    chk("abort_no_done", nDone - snapDone, 0);
    chk("reinit_cmd", 32'(flashCmd), 32'h66);
    runLen(1'b0, n);
    chk("reinit_len", n, 32);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
